// File: rtl/game_ctrl.sv
// game_ctrl: control FSM sequencing the Minesweeper datapath.
// Issues one-hot command strobes (start/load/decode/alu/display), consumes
// the matching done/status returns, filters illegal or repeated moves,
// counts accepted moves per game and traps a handshake that never completes.
//
// Ports:
//   clka, restart_n      clock, synchronous active-low reset
//   new_game             request to begin a game (IDLE/OVER/ERROR only)
//   move_valid, move_pos move strobe and requested cell index
//   *_done               datapath completion for each waited command
//   gameover, win        datapath status, sampled with alu_done
//   start..display       command strobes, one-hot, high while in their state
//   data                 accepted move index presented to the datapath
//   ready                accepting moves
//   move_rej             one-cycle pulse on a rejected move
//   won, lost            result of the last game
//   err                  handshake timeout trap
//   move_cnt             accepted moves this game (saturating)
module game_ctrl #(
  parameter int unsigned CELLS   = 25,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned MOVE_W  = 8
) (
  input  logic              clka,
  input  logic              restart_n,
  input  logic              new_game,
  input  logic              move_valid,
  input  logic [4:0]        move_pos,
  input  logic              place_done,
  input  logic              decode_done,
  input  logic              alu_done,
  input  logic              display_done,
  input  logic              gameover,
  input  logic              win,
  output logic              start,
  output logic              load,
  output logic              decode,
  output logic              alu,
  output logic              display,
  output logic [4:0]        data,
  output logic              ready,
  output logic              move_rej,
  output logic              won,
  output logic              lost,
  output logic              err,
  output logic [MOVE_W-1:0] move_cnt
);

  localparam int unsigned     TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, PLACE, WAIT_MOVE, LOAD, DECODE, ALU, DISPLAY, OVER, ERROR
  } state_t;

  state_t           state;
  logic [CELLS-1:0] cleared;
  logic [TMR_W-1:0] tmr;
  logic             gm_cap;
  logic             win_cap;

  logic             done_sel;
  logic             done_ok;
  logic             tmr_exp;
  logic [CELLS-1:0] move_bit;
  logic             move_bad;

  // Done belonging to the current wait state; others are ignored.
  always_comb begin
    done_sel = 1'b0;
    case (state)
      PLACE:   done_sel = place_done;
      DECODE:  done_sel = decode_done;
      ALU:     done_sel = alu_done;
      DISPLAY: done_sel = display_done;
      default: done_sel = 1'b0;
    endcase
  end

  // First wait cycle (tmr==0) masks a done left high from the previous step.
  always_comb begin
    done_ok  = done_sel && (tmr != '0);
    tmr_exp  = (tmr == TMR_LAST);
    move_bit = CELLS'(1) << move_pos;
    move_bad = (32'(move_pos) >= CELLS) || ((cleared & move_bit) != '0);
  end

  // FSM with registered outputs: each branch sets the outputs of the state
  // being entered; strobes default low every cycle.
  always_ff @(posedge clka) begin
    if (!restart_n) begin
      state    <= IDLE;
      start    <= 1'b0;
      load     <= 1'b0;
      decode   <= 1'b0;
      alu      <= 1'b0;
      display  <= 1'b0;
      data     <= '0;
      ready    <= 1'b0;
      move_rej <= 1'b0;
      won      <= 1'b0;
      lost     <= 1'b0;
      err      <= 1'b0;
      move_cnt <= '0;
      cleared  <= '0;
      tmr      <= '0;
      gm_cap   <= 1'b0;
      win_cap  <= 1'b0;
    end else begin
      start    <= 1'b0;
      load     <= 1'b0;
      decode   <= 1'b0;
      alu      <= 1'b0;
      display  <= 1'b0;
      ready    <= 1'b0;
      move_rej <= 1'b0;

      case (state)
        IDLE, OVER, ERROR: begin
          if (new_game) begin
            state    <= PLACE;
            start    <= 1'b1;
            tmr      <= '0;
            won      <= 1'b0;
            lost     <= 1'b0;
            err      <= 1'b0;
            move_cnt <= '0;
            cleared  <= '0;
          end
        end

        PLACE: begin
          if (done_ok) begin
            state <= WAIT_MOVE;
            ready <= 1'b1;
          end else if (tmr_exp) begin
            state <= ERROR;
            err   <= 1'b1;
          end else begin
            start <= 1'b1;
            tmr   <= tmr + TMR_W'(1);
          end
        end

        WAIT_MOVE: begin
          if (move_valid && move_bad) begin
            move_rej <= 1'b1;
            ready    <= 1'b1;
          end else if (move_valid) begin
            state   <= LOAD;
            load    <= 1'b1;
            data    <= move_pos;
            cleared <= cleared | move_bit;
            if (move_cnt != '1) move_cnt <= move_cnt + MOVE_W'(1);
          end else begin
            ready <= 1'b1;
          end
        end

        // Load has no done; it lasts exactly one cycle.
        LOAD: begin
          state  <= DECODE;
          decode <= 1'b1;
          tmr    <= '0;
        end

        DECODE: begin
          if (done_ok) begin
            state <= ALU;
            alu   <= 1'b1;
            tmr   <= '0;
          end else if (tmr_exp) begin
            state <= ERROR;
            err   <= 1'b1;
          end else begin
            decode <= 1'b1;
            tmr    <= tmr + TMR_W'(1);
          end
        end

        // Status is only valid alongside alu_done, so capture it there.
        ALU: begin
          if (done_ok) begin
            state   <= DISPLAY;
            display <= 1'b1;
            tmr     <= '0;
            gm_cap  <= gameover;
            win_cap <= win;
          end else if (tmr_exp) begin
            state <= ERROR;
            err   <= 1'b1;
          end else begin
            alu <= 1'b1;
            tmr <= tmr + TMR_W'(1);
          end
        end

        // Win outranks gameover when both are reported.
        DISPLAY: begin
          if (done_ok) begin
            if (win_cap) begin
              state <= OVER;
              won   <= 1'b1;
            end else if (gm_cap) begin
              state <= OVER;
              lost  <= 1'b1;
            end else begin
              state <= WAIT_MOVE;
              ready <= 1'b1;
            end
          end else if (tmr_exp) begin
            state <= ERROR;
            err   <= 1'b1;
          end else begin
            display <= 1'b1;
            tmr     <= tmr + TMR_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: datapath responder returning done on the 2nd cycle of
// each command, a move scoreboard checked at load/move_rej, and directed
// checks on flags, latency, command order, timeout and reset.
module tb_game_ctrl;

  localparam int unsigned CELLS   = 25;
  localparam int unsigned TIMEOUT = 255;
  localparam int unsigned MOVE_W  = 8;

  logic              clka = 1'b0;
  logic              restart_n;
  logic              new_game;
  logic              move_valid;
  logic [4:0]        move_pos;
  logic              place_done   = 1'b0;
  logic              decode_done  = 1'b0;
  logic              alu_done     = 1'b0;
  logic              display_done = 1'b0;
  logic              gameover;
  logic              win;
  logic              start, load, decode, alu, display;
  logic [4:0]        data;
  logic              ready, move_rej, won, lost, err;
  logic [MOVE_W-1:0] move_cnt;

  game_ctrl #(.CELLS(CELLS), .TIMEOUT(TIMEOUT), .MOVE_W(MOVE_W)) dut (
    .clka(clka), .restart_n(restart_n), .new_game(new_game),
    .move_valid(move_valid), .move_pos(move_pos),
    .place_done(place_done), .decode_done(decode_done),
    .alu_done(alu_done), .display_done(display_done),
    .gameover(gameover), .win(win),
    .start(start), .load(load), .decode(decode), .alu(alu), .display(display),
    .data(data), .ready(ready), .move_rej(move_rej), .won(won), .lost(lost),
    .err(err), .move_cnt(move_cnt)
  );

  always #5 clka = ~clka;

  typedef struct {
    logic              rej;
    logic [4:0]        pos;
    logic [MOVE_W-1:0] cnt;
  } exp_t;

  exp_t              sb_q[$];
  int                n_chk = 0;
  int                n_err = 0;
  int                onehot_viol = 0;
  logic              hold_alu = 1'b0;
  logic [CELLS-1:0]  b_cleared;
  logic [MOVE_W-1:0] exp_cnt;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({start, load, decode, alu, display, data, ready, move_rej,
                won, lost, err, move_cnt});
  endfunction

  function automatic logic [2:0] cmd_code();
    if (load)    return 3'd1;
    if (decode)  return 3'd2;
    if (alu)     return 3'd3;
    if (display) return 3'd4;
    return 3'd0;
  endfunction

  task automatic tick();
    @(negedge clka);
  endtask

  // Datapath responder: done pulses on the 2nd cycle its command is high.
  initial begin
    int run_s, run_d, run_a, run_p;
    run_s = 0; run_d = 0; run_a = 0; run_p = 0;
    forever begin
      @(negedge clka);
      run_s = start   ? run_s + 1 : 0;
      run_d = decode  ? run_d + 1 : 0;
      run_a = alu     ? run_a + 1 : 0;
      run_p = display ? run_p + 1 : 0;
      place_done   = (run_s == 2);
      decode_done  = (run_d == 2);
      alu_done     = (run_a == 2) && !hold_alu;
      display_done = (run_p == 2);
    end
  end

  // Scoreboard side: each load or move_rej consumes one expected move.
  always @(negedge clka) begin
    if (restart_n === 1'b1) begin
      if ($countones({start, load, decode, alu, display}) > 1) onehot_viol++;
      if (load || move_rej) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_event", 32'(1), 32'(0));
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_kind", 32'(move_rej), 32'(e.rej));
          check("sb_cnt", 32'(move_cnt), 32'(e.cnt));
          if (load) check("sb_data", 32'(data), 32'(e.pos));
        end
      end
    end
  end

  task automatic begin_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    b_cleared = '0;
    exp_cnt = '0;
  endtask

  task automatic wait_place(output int n_start);
    int i;
    n_start = 0;
    i = 0;
    while (!ready && i < 50) begin
      if (start) n_start++;
      tick();
      i++;
    end
    check("ready_wait", 32'(ready), 32'(1));
  endtask

  // Model decides accept/reject and pushes the expectation before driving.
  task automatic send_move(input int pos);
    logic acc;
    acc = 1'b0;
    if (pos < int'(CELLS)) acc = !b_cleared[pos];
    if (acc) begin
      b_cleared[pos] = 1'b1;
      if (exp_cnt != '1) exp_cnt = exp_cnt + MOVE_W'(1);
    end
    sb_q.push_back('{rej: !acc, pos: 5'(pos), cnt: exp_cnt});
    move_pos = 5'(pos);
    move_valid = 1'b1;
    tick();
    move_valid = 1'b0;
  endtask

  task automatic follow(output int lat, output logic [31:0] tr);
    lat = 1;
    tr = '0;
    while (!(ready || won || lost || err) && lat < 400) begin
      tr = (tr << 3) | 32'(cmd_code());
      tick();
      lat++;
    end
    check("move_settle", 32'(ready || won || lost || err), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          n, lat, i;
    logic [31:0] tr;
    logic [31:0] exp_seq;
    exp_seq = 32'({3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4});

    restart_n = 1'b0; new_game = 1'b0; move_valid = 1'b0; move_pos = '0;
    gameover = 1'b0; win = 1'b0; b_cleared = '0; exp_cnt = '0;
    repeat (3) tick();
    check("reset_outs", outs(), 32'(0));
    restart_n = 1'b1;
    tick();
    check("idle_ready", 32'(ready), 32'(0));

    // Game 1: placement handshake
    begin_game();
    wait_place(n);
    check("start_cycles", 32'(n), 32'(2));
    check("cnt_start", 32'(move_cnt), 32'(0));

    // Plain move: command order and latency
    send_move(7);
    follow(lat, tr);
    check("latency", 32'(lat), 32'(8));
    check("cmd_seq", tr, exp_seq);
    check("ready_back", 32'(ready), 32'(1));
    check("no_result", 32'({won, lost, err}), 32'(0));

    // Repeated cell and out-of-range cell
    send_move(7);
    check("rej_repeat", 32'({move_rej, start, load, decode, alu, display, ready}), 32'(7'b1000001));
    send_move(25);
    check("rej_range", 32'({move_rej, start, load, decode, alu, display, ready}), 32'(7'b1000001));
    tick();
    check("rej_pulse_end", 32'(move_rej), 32'(0));
    check("cnt_after_rej", 32'(move_cnt), 32'(1));

    // Mine hit
    gameover = 1'b1;
    send_move(12);
    follow(lat, tr);
    check("lose_flags", 32'({won, lost, ready}), 32'(3'b010));
    move_pos = 5'd3;
    move_valid = 1'b1;
    tick();
    move_valid = 1'b0;
    check("over_no_rej", 32'({move_rej, load, move_cnt}), 32'(2));
    gameover = 1'b0;

    // Game 2: flags cleared, mask cleared, win beats gameover
    begin_game();
    check("ng_clear", 32'({won, lost, move_cnt}), 32'(0));
    check("ng_start", 32'(start), 32'(1));
    wait_place(n);
    send_move(7);
    follow(lat, tr);
    check("reuse_cell_ready", 32'(ready), 32'(1));
    gameover = 1'b1;
    win = 1'b1;
    send_move(3);
    follow(lat, tr);
    check("win_flags", 32'({won, lost}), 32'(2'b10));
    check("win_cnt", 32'(move_cnt), 32'(2));
    gameover = 1'b0;
    win = 1'b0;

    // Game 3: alu_done withheld until timeout
    begin_game();
    wait_place(n);
    hold_alu = 1'b1;
    send_move(5);
    n = 0;
    i = 0;
    while (!err && i < 400) begin
      if (alu) n++;
      tick();
      i++;
    end
    check("alu_hold_cycles", 32'(n), 32'(TIMEOUT));
    check("err_set", 32'(err), 32'(1));
    check("err_cmds_low", 32'({start, load, decode, alu, display, ready}), 32'(0));
    hold_alu = 1'b0;
    begin_game();
    check("err_cleared", 32'(err), 32'(0));
    check("err_ng_start", 32'(start), 32'(1));
    wait_place(n);

    // Reset in the middle of DECODE
    send_move(9);
    i = 0;
    while (!decode && i < 10) begin
      tick();
      i++;
    end
    check("in_decode", 32'(decode), 32'(1));
    restart_n = 1'b0;
    tick();
    check("mid_reset_outs", outs(), 32'(0));
    restart_n = 1'b1;
    tick();
    check("post_reset_idle", outs(), 32'(0));

    check("sb_drained", 32'(sb_q.size()), 32'(0));
    check("onehot", 32'(onehot_viol), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Control FSM that sequences the Minesweeper datapath. It issues the start/load/decode/alu/display command strobes, consumes the matching *_done, gameover and win status, and presents the datapath with 5-bit board moves.
- It is the initiator side of the datapath command/done handshake.
- Filters illegal and repeated moves, counts moves per game, and traps a handshake that never completes.

Parameters:
- CELLS, 25, number of board cells; moves >= CELLS are illegal.
- TIMEOUT, 255, max cycles allowed in any wait-for-done state before entering ERROR.
- MOVE_W, 8, width of the per-game move counter.

Ports:
- clka  input  1  sole clock; all state updates on posedge.
- restart_n  input  1  synchronous, active-low reset.
- new_game  input  1  single-cycle request to begin a game.
- move_valid  input  1  single-cycle strobe; move_pos is valid.
- move_pos  input  5  requested cell index.
- place_done  input  1  datapath done for start.
- decode_done  input  1  datapath done for decode.
- alu_done  input  1  datapath done for alu.
- display_done  input  1  datapath done for display.
- gameover  input  1  datapath status, valid while alu_done=1.
- win  input  1  datapath status, valid while alu_done=1.
- start  output  1  place-mines command.
- load  output  1  load-move command.
- decode  output  1  decode command.
- alu  output  1  evaluate command.
- display  output  1  display command.
- data  output  5  move index to the datapath.
- ready  output  1  high in WAIT_MOVE (accepting moves).
- move_rej  output  1  one-cycle pulse when a move is rejected.
- won  output  1  last game ended in a win.
- lost  output  1  last game ended on a mine.
- err  output  1  handshake timeout trap.
- move_cnt  output  MOVE_W  accepted moves this game.

Behaviour:
- Reset: restart_n=0 at posedge gives state IDLE and zeroes every output: start, load, decode, alu, display, data, ready, move_rej, won, lost, err, move_cnt. It also zeroes the internal cleared mask (CELLS bits), the timeout counter and the captured status. Reset overrides everything, including mid-handshake.
- All outputs are registered. Exactly one command output is high, and only while in its state.
- IDLE: new_game moves to PLACE; it also clears won, lost, move_cnt and the cleared mask.
- PLACE: start=1. Exit to WAIT_MOVE on place_done.
- WAIT_MOVE: ready=1. On move_valid:
  - move_pos >= CELLS, or cleared[move_pos]=1: pulse move_rej next cycle and stay.
  - Otherwise latch data=move_pos, set cleared[move_pos], increment move_cnt (saturating at all-ones), and go to LOAD.
  - move_valid outside WAIT_MOVE is ignored, with no move_rej.
- LOAD: load=1 for exactly 1 cycle, then DECODE. There is no done for load.
- DECODE: decode=1 until decode_done, then ALU.
- ALU: alu=1 until alu_done. On that cycle capture gameover and win, then go to DISPLAY.
- DISPLAY: display=1 until display_done. Then:
  - captured win=1: won=1, go to OVER.
  - else captured gameover=1: lost=1, go to OVER.
  - else: go to WAIT_MOVE.
  - win takes priority over gameover.
- OVER: all commands low; won/lost hold. new_game goes to PLACE and clears won, lost, move_cnt and cleared. The datapath keeps its own score.
- Done qualification:
  - A done is accepted only from the 2nd cycle of its wait state onward; the first cycle is ignored, which masks stale level-held done from the datapath.
  - A done high in the wrong state is ignored.
- Timeout:
  - The counter is reset on entry to PLACE, DECODE, ALU and DISPLAY, and increments each cycle while waiting.
  - If it reaches TIMEOUT without a qualified done: go to ERROR with err=1 and all commands low.
  - ERROR exits only on new_game (to PLACE, err cleared) or on reset.
- new_game is ignored in PLACE, LOAD, DECODE, ALU and DISPLAY.
- Latency, moves 1..24 (move_valid to the next ready), with single-cycle done responses:
  - move_valid to LOAD: 1 cycle.
  - LOAD, then DECODE, ALU and DISPLAY at 2 cycles each.
  - ready returns 8 cycles after move_valid.

Test Plan:
- Reset, new_game, place_done on 2nd cycle of PLACE -> start high exactly 2 cycles, then ready=1, move_cnt=0.
- Move 7 with a responder returning gameover=0, win=0 -> load, decode, alu, display each one-hot in order; data=7; move_cnt=1; ready returns 8 cycles after move_valid.
- Move 7 again, then move 25 -> two move_rej pulses, no command asserted, move_cnt stays 1.
- Move 12 with responder gameover=1, win=0 -> lost=1, won=0, OVER. Then new_game -> lost=0, move_cnt=0, start=1.
- Move with responder win=1, gameover=1 -> won=1, lost=0.
- Responder withholds alu_done for TIMEOUT cycles -> err=1, alu=0. Then new_game -> err=0, start=1. Separately, restart_n=0 mid-DECODE -> all outputs 0 next cycle.
